// File: rtl/nonce_scan_pkg.sv
// ============================================================================
// Module      : nonce_scan_pkg
// Description : Shared constants and FSM state type for the nonce scan
//               controller and its header register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nonce_scan_pkg;

  // Datapath widths
  localparam int NONCE_W             = 32;
  localparam int WORD_W              = 32;
  localparam int HDR_WORDS_DEFAULT   = 19;
  // Word index must reach HDR_WORDS (the nonce slot), so 5 bits cover 0..31
  localparam int IDX_W               = 5;

  // FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_WAIT  = ST_WAIT,
    S_CHECK = ST_CHECK
  } state_e;

endpackage : nonce_scan_pkg

`default_nettype wire

// File: rtl/nonce_scan_ctrl_hdr_regfile.sv
// ============================================================================
// Module      : hdr_regfile
// Description : Block-header storage, HDR_WORDS x 32 bits. Synchronous write,
//               combinational read by word index. Out-of-range addresses are
//               ignored on write and read back as zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdr_regfile
  import nonce_scan_pkg::*;
#(
  parameter int HDR_WORDS = HDR_WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [HDR_WORDS];

  // Header words: cleared on reset, one word written per strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < HDR_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int i = 0; i < HDR_WORDS; i++) begin
        if (waddr == IDX_W'(i)) begin
          mem[i] <= wdata;
        end
      end
    end
  end

  // Read mux; an index past the last header word yields zero
  always_comb begin
    rdata = '0;
    for (int i = 0; i < HDR_WORDS; i++) begin
      if (raddr == IDX_W'(i)) begin
        rdata = mem[i];
      end
    end
  end

endmodule : hdr_regfile

`default_nettype wire

// File: rtl/nonce_scan_ctrl.sv
// ============================================================================
// Module      : nonce_scan_ctrl
// Description : Nonce search sequencer for a shared SHA-256 core. Streams the
//               stored header plus the current nonce (HDR_WORDS+1 words) on
//               the block bus, waits for the hash, tests the leading-zero
//               difficulty, and steps the nonce through an inclusive range
//               (wrapping modulo 2^32).
//               Optional build macro NONCE_SCAN_TIMEOUT_EN adds a WAIT-state
//               watchdog (TIMEOUT_CYCLES) and the timeout_err output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nonce_scan_ctrl
  import nonce_scan_pkg::*;
#(
  parameter int HDR_WORDS      = HDR_WORDS_DEFAULT,
  parameter int ZERO_BITS      = 16
`ifdef NONCE_SCAN_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  input  logic               hdr_we,
  input  logic [IDX_W-1:0]   hdr_addr,
  input  logic [WORD_W-1:0]  hdr_wdata,
  output logic [WORD_W-1:0]  block,
  output logic               block_valid,
  input  logic               block_ready,
  input  logic               sha_done,
  input  logic [31:0]        sha_hash_msw,
  output logic               valid,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               busy,
  output logic               exhausted
`ifdef NONCE_SCAN_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_WORDS);

  state_e             state;
  logic [IDX_W-1:0]   idx;
  logic [NONCE_W-1:0] nonce;
  logic [NONCE_W-1:0] nonce_last;
  logic [31:0]        hash_cap;
  logic [WORD_W-1:0]  hdr_word;
  logic               hdr_wr_en;
  logic               hit;
  logic               word_accept;
  logic               wait_expired;

  // Header may only change between scans
  assign hdr_wr_en   = hdr_we && (state == S_IDLE);
  assign word_accept = block_valid && block_ready;
  assign busy        = (state != S_IDLE);

  // Hit when the top ZERO_BITS bits of the captured hash are all zero
  assign hit = ((hash_cap >> (32 - ZERO_BITS)) == 32'd0);

  hdr_regfile #(
    .HDR_WORDS (HDR_WORDS)
  ) u_hdr (
    .clk   (clk),
    .rst   (rst),
    .we    (hdr_wr_en),
    .waddr (hdr_addr),
    .wdata (hdr_wdata),
    .raddr (idx),
    .rdata (hdr_word)
  );

  // Block bus: header words first, nonce in the final slot; held while stalled
  always_comb begin
    block       = '0;
    block_valid = 1'b0;
    if (state == S_LOAD) begin
      block_valid = 1'b1;
      block       = (idx < LAST_IDX) ? hdr_word : nonce;
    end
  end

`ifdef NONCE_SCAN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wait_cnt;

  // Watchdog counter: zero outside WAIT, so every WAIT entry starts fresh
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state != S_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog error pulse, suppressed by abort and by a same-cycle sha_done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= (state == S_WAIT) && !abort && !sha_done && wait_expired;
    end
  end
`else
  assign wait_expired = 1'b0;
`endif

  // Main sequencer; abort overrides every transition and suppresses pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      nonce       <= '0;
      nonce_last  <= '0;
      hash_cap    <= '0;
      valid       <= 1'b0;
      exhausted   <= 1'b0;
      found_nonce <= '0;
    end else begin
      valid     <= 1'b0;
      exhausted <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        idx   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              nonce      <= nonce_start;
              nonce_last <= nonce_end;
              idx        <= '0;
              state      <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (word_accept) begin
              if (idx == LAST_IDX) begin
                idx   <= '0;
                state <= S_WAIT;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
          S_WAIT: begin
            if (sha_done) begin
              hash_cap <= sha_hash_msw;
              state    <= S_CHECK;
            end else if (wait_expired) begin
              state <= S_IDLE;
            end
          end
          S_CHECK: begin
            if (hit) begin
              valid       <= 1'b1;
              found_nonce <= nonce;
              state       <= S_IDLE;
            end else if (nonce == nonce_last) begin
              exhausted <= 1'b1;
              state     <= S_IDLE;
            end else begin
              nonce <= nonce + NONCE_W'(1);
              state <= S_LOAD;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule : nonce_scan_ctrl

`default_nettype wire

// File: tb/tb_nonce_scan_ctrl.sv
// ============================================================================
// Module      : tb_nonce_scan_ctrl
// Description : Scoreboard bench for nonce_scan_ctrl. Directed scans push the
//               expected block words, hits and exhaust events into queues; a
//               negedge monitor pops and compares on every DUT output event
//               and also plays the SHA core (sha_done two cycles after the
//               last word). With NONCE_SCAN_TIMEOUT_EN the watchdog is tested.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nonce_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] nonce_start;
  logic [31:0] nonce_end;
  logic        hdr_we;
  logic [4:0]  hdr_addr;
  logic [31:0] hdr_wdata;
  logic [31:0] block;
  logic        block_valid;
  logic        block_ready;
  logic        sha_done;
  logic [31:0] sha_hash_msw;
  logic        valid;
  logic [31:0] found_nonce;
  logic        busy;
  logic        exhausted;
`ifdef NONCE_SCAN_TIMEOUT_EN
  logic        timeout_err;
`endif

  always #5 clk = ~clk;

  nonce_scan_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .nonce_start  (nonce_start),
    .nonce_end    (nonce_end),
    .hdr_we       (hdr_we),
    .hdr_addr     (hdr_addr),
    .hdr_wdata    (hdr_wdata),
    .block        (block),
    .block_valid  (block_valid),
    .block_ready  (block_ready),
    .sha_done     (sha_done),
    .sha_hash_msw (sha_hash_msw),
    .valid        (valid),
    .found_nonce  (found_nonce),
    .busy         (busy),
    .exhausted    (exhausted)
`ifdef NONCE_SCAN_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_word_q [$];
  logic [31:0] exp_hit_q  [$];
  logic [31:0] hash_q     [$];
  int          exp_exh    = 0;
  logic [31:0] hdr_model  [19];
  bit          sha_en     = 1'b1;
  int          ready_mode = 0;   // 0: always ready, 1: toggle each cycle
  int          acc_cnt    = 0;
  bit          fire_next  = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] prev_block = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor and SHA responder: drive inputs for the coming edge, then score outputs
  always @(negedge clk) begin
    sha_done = fire_next;
    if (fire_next) begin
      sha_hash_msw = (hash_q.size() > 0) ? hash_q.pop_front() : 32'hFFFF_FFFF;
    end
    fire_next   = 1'b0;
    block_ready = (ready_mode == 1) ? ~block_ready : 1'b1;

    if (rst) begin
      if (stall_prev && block_valid) begin
        chk("stall_stable", block, prev_block);
      end
      stall_prev = block_valid && !block_ready;
      prev_block = block;

      if (block_valid && block_ready) begin
        if (exp_word_q.size() == 0) begin
          chk("unexpected_word", block, 32'hXXXX_XXXX);
        end else begin
          chk("block_word", block, exp_word_q.pop_front());
        end
        acc_cnt++;
        if (acc_cnt == 20) begin
          acc_cnt   = 0;
          fire_next = sha_en;
        end
      end

      if (valid) begin
        if (exp_hit_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          chk("found_nonce", found_nonce, exp_hit_q.pop_front());
        end
      end

      if (exhausted) begin
        if (exp_exh == 0) begin
          chk("unexpected_exhausted", 32'd1, 32'd0);
        end else begin
          tests++;
          exp_exh--;
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic wr_hdr(input int i, input logic [31:0] d, input bit taken);
    @(posedge clk); #1;
    hdr_we    = 1'b1;
    hdr_addr  = 5'(i);
    hdr_wdata = d;
    @(posedge clk); #1;
    hdr_we = 1'b0;
    if (taken) hdr_model[i] = d;
  endtask

  task automatic push_nonce(input logic [31:0] n, input logic [31:0] h);
    for (int i = 0; i < 19; i++) exp_word_q.push_back(hdr_model[i]);
    exp_word_q.push_back(n);
    hash_q.push_back(h);
  endtask

  task automatic start_scan(input logic [31:0] s, input logic [31:0] e);
    @(posedge clk); #1;
    nonce_start = s;
    nonce_end   = e;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 3000);
    chk(name, {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain_check(input string name);
    chk({name, "_words_left"}, exp_word_q.size(), 0);
    chk({name, "_hits_left"},  exp_hit_q.size(),  0);
    chk({name, "_exh_left"},   exp_exh,           0);
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; abort = 1'b0; nonce_start = '0; nonce_end = '0;
    hdr_we = 1'b0; hdr_addr = '0; hdr_wdata = '0; block_ready = 1'b1;
    sha_done = 1'b0; sha_hash_msw = '0;
    for (int i = 0; i < 19; i++) hdr_model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_block",       block,                0);
    chk("rst_block_valid", {31'd0, block_valid}, 0);
    chk("rst_busy",        {31'd0, busy},        0);
    chk("rst_valid",       {31'd0, valid},       0);
    chk("rst_exhausted",   {31'd0, exhausted},   0);
    chk("rst_found_nonce", found_nonce,          0);
    rst = 1'b1;

    // 1: single nonce, hit; latency 20 LOAD + 1 WAIT + 1 CHECK
    for (int i = 0; i < 19; i++) wr_hdr(i, 32'h100 + 32'(i), 1'b1);
    push_nonce(32'd5, 32'h0000_1234);
    exp_hit_q.push_back(32'd5);
    start_scan(32'd5, 32'd5);
    wait_idle("t1_done", n);
    chk("t1_latency", 32'(n), 32'd22);
    chk("t1_found", found_nonce, 32'd5);
    drain_check("t1");

    // 2: range 0..3, all misses -> exhausted, no valid
    for (int k = 0; k < 4; k++) push_nonce(32'(k), 32'h8000_0000);
    exp_exh = 1;
    start_scan(32'd0, 32'd3);
    wait_idle("t2_done", n);
    chk("t2_found_held", found_nonce, 32'd5);
    drain_check("t2");

    // 3: backpressure every other cycle; header write while busy is dropped
    ready_mode = 1;
    push_nonce(32'd9, 32'h0000_0000);
    exp_hit_q.push_back(32'd9);
    start_scan(32'd9, 32'd9);
    wr_hdr(0, 32'hDEAD_BEEF, 1'b0);
    wait_idle("t3_done", n);
    ready_mode = 0;
    drain_check("t3");

    // 4: wrap through 0xFFFFFFFF; 0x00010000 is just a miss, 0x0000FFFF a hit
    push_nonce(32'hFFFF_FFFE, 32'h8000_0000);
    push_nonce(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push_nonce(32'h0000_0000, 32'h0001_0000);
    push_nonce(32'h0000_0001, 32'h0000_FFFF);
    exp_hit_q.push_back(32'd1);
    start_scan(32'hFFFF_FFFE, 32'h0000_0001);
    wait_idle("t4_done", n);
    chk("t4_found", found_nonce, 32'd1);
    drain_check("t4");

    // 5a: abort while word 7 is presented
    for (int i = 0; i < 8; i++) exp_word_q.push_back(hdr_model[i]);
    start_scan(32'd0, 32'd10);
    repeat (7) @(posedge clk);
    #1;
    chk("t5_idx7_word", block, 32'h107);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_abort_busy",  {31'd0, busy},        0);
    chk("t5_abort_bv",    {31'd0, block_valid}, 0);
    chk("t5_abort_block", block,                0);
    acc_cnt = 0;
    repeat (3) @(posedge clk);
    drain_check("t5a");

    // 5b: asynchronous reset while in WAIT
    sha_en = 1'b0;
    push_nonce(32'd3, 32'h0);
    void'(hash_q.pop_back());
    start_scan(32'd3, 32'd3);
    n = 0;
    while (!(busy && !block_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_reached_wait", {31'd0, busy && !block_valid}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t5_rst_busy",  {31'd0, busy},        0);
    chk("t5_rst_bv",    {31'd0, block_valid}, 0);
    chk("t5_rst_found", found_nonce,          0);
    chk("t5_rst_valid", {31'd0, valid},       0);
    @(posedge clk); #1;
    rst = 1'b1;
    acc_cnt = 0;
    sha_en  = 1'b1;
    for (int i = 0; i < 19; i++) hdr_model[i] = '0;
    drain_check("t5b");

    // 5c: header registers were cleared by reset
    push_nonce(32'd2, 32'hFFFF_FFFF);
    exp_exh = 1;
    start_scan(32'd2, 32'd2);
    wait_idle("t5c_done", n);
    drain_check("t5c");

`ifdef NONCE_SCAN_TIMEOUT_EN
    // 6: watchdog fires after 256 WAIT cycles without sha_done
    sha_en = 1'b0;
    push_nonce(32'd4, 32'h0);
    void'(hash_q.pop_back());
    start_scan(32'd4, 32'd4);
    n = 0;
    while (!(busy && !block_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n = 1;
    while (!timeout_err && n < 1000) begin
      @(posedge clk); #1;
      if (!timeout_err) n++;
    end
    chk("t6_timeout_seen",   {31'd0, timeout_err}, 32'd1);
    chk("t6_timeout_cycles", 32'(n),               32'd256);
    chk("t6_busy",           {31'd0, busy},        32'd0);
    acc_cnt = 0;
    sha_en  = 1'b1;
    drain_check("t6");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_nonce_scan_ctrl

`default_nettype wire
